alu_arbiter: RTL and testbench

// - Shares one 8-bit ALU datapath (AND / OR / shift-left / add) between two requesters.
// - Round-robin arbiter plus sequencer:
//   - accepts one operation at a time on a valid/ready request channel;
//   - drives the ALU operand and opcode inputs from internal registers;
//   - captures the ALU result;
//   - returns the result on the granted requester's valid/ready response channel.
// - Sits between the requesting blocks and the alu instance.

---
 rtl/alu_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer that shares one ALU
// datapath (AND / OR / shift-left / add) between two requesters.
// A single operation is in flight at a time: accept -> EXEC for ALU_LAT
// cycles -> RESP until the owner takes the result.
// Optional build macro ALU_ARB_STATS_EN adds per-requester grant counters
// (grant_cnt0, grant_cnt1) and a synchronous clear input (stats_clr).
// ALU_LAT must lie in 1..15 so the latency counter fits in four bits.

module alu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef ALU_ARB_STATS_EN
    input  logic             stats_clr,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1,
`endif
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Remaining EXEC cycles after the accept edge; zero means capture now.
    localparam logic [3:0] CNT_LOAD = 4'(ALU_LAT - 1);

    state_t           state;
    state_t           state_nxt;
    logic             sel;
    logic             owner;
    logic             last_grant;
    logic             accept;
    logic             transfer;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       cnt;

    // Round-robin pick: a lone requester wins; on contention the one not
    // granted last time wins.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last_grant;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    assign accept   = (state == IDLE) && (req0_valid || req1_valid);
    assign transfer = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default before the case,
        // so no path through it can infer a latch.
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                // Ready is gated by rst_n so the combinational path stays
                // quiet while reset is held with a request pending.
                req0_ready = rst_n && req0_valid && !sel;
                req1_ready = rst_n && req1_valid && sel;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp0_valid = !owner;
                rsp1_valid = owner;
                if (transfer) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand/opcode latch on accept, latency countdown, result capture
    // and round-robin pointer update on the response transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all datapath registers are reset, not just control, so
            // the ALU inputs and response data read 0 while in reset.
            op_q       <= 2'd0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            cnt        <= 4'd0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge value of the others.
            if (accept) begin
                op_q  <= sel ? req1_op : req0_op;
                a_q   <= sel ? req1_a  : req0_a;
                b_q   <= sel ? req1_b  : req0_b;
                owner <= sel;
                cnt   <= CNT_LOAD;
            end
            if (state == EXEC) begin
                if (cnt == 4'd0) begin
                    result_q <= alu_out;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
            if (transfer) begin
                last_grant <= owner;
            end
        end
    end

    // The ALU sees only the latched operands, so they stay stable through EXEC.
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

    // Both response ports share the captured result; only the owner's
    // valid is ever raised, so the other port's data is don't-care.
    assign rsp0_data = result_q;
    assign rsp1_data = result_q;

`ifdef ALU_ARB_STATS_EN
    // Saturating grant counters; a clear wins over a same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else if (stats_clr) begin
            grant_cnt0 <= 16'd0;
            grant_cnt1 <= 16'd0;
        end else begin
            if (accept && !sel && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (accept && sel && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`else
    // Without statistics there is no per-requester accounting to build.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus randomized checks of alu_arbiter.
// Two instances run side by side: ALU_LAT=1 and ALU_LAT=4. A combinational
// ALU stub answers each instance. Expected grants, latencies and results
// come from a transaction-level model: who was served last, and plain
// arithmetic on the accepted operands.

module tb_alu_arbiter;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n      [2];
    logic [1:0]            req_valid  [2];
    logic [1:0][1:0]       req_op     [2];
    logic [1:0][W-1:0]     req_a      [2];
    logic [1:0][W-1:0]     req_b      [2];
    logic [1:0]            rsp_ready  [2];
    logic                  req_ready0 [2];
    logic                  req_ready1 [2];
    logic                  rsp_valid0 [2];
    logic                  rsp_valid1 [2];
    logic [W-1:0]          rsp_data0  [2];
    logic [W-1:0]          rsp_data1  [2];
    logic [1:0]            alu_op     [2];
    logic [W-1:0]          alu_a      [2];
    logic [W-1:0]          alu_b      [2];
    logic [W-1:0]          alu_out    [2];
`ifdef ALU_ARB_STATS_EN
    logic                  stats_clr  [2];
    logic [15:0]           gcnt0      [2];
    logic [15:0]           gcnt1      [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model state.
    int           last_served [2];
    bit           pend        [2][2];
    logic [1:0]   q_op        [2][2];
    logic [W-1:0] q_a         [2][2];
    logic [W-1:0] q_b         [2][2];
    int           gexp        [2][2];
    bit           clr_at_accept;

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Reference ALU arithmetic, done on integers and reduced mod 2^W.
    function automatic logic [W-1:0] alu_ref(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        int r;
        case (op)
            2'd0:    r = int'(a & b);
            2'd1:    r = int'(a | b);
            2'd2:    r = (int'(b) >= W) ? 0 : int'(a) * (1 << int'(b));
            default: r = int'(a) + int'(b);
        endcase
        return W'(r % (1 << W));
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alu_arbiter #(
            .WIDTH   (W),
            .ALU_LAT (gi == 0 ? 1 : 4)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[gi]),
`ifdef ALU_ARB_STATS_EN
            .stats_clr  (stats_clr[gi]),
            .grant_cnt0 (gcnt0[gi]),
            .grant_cnt1 (gcnt1[gi]),
`endif
            .req0_valid (req_valid[gi][0]),
            .req0_ready (req_ready0[gi]),
            .req0_op    (req_op[gi][0]),
            .req0_a     (req_a[gi][0]),
            .req0_b     (req_b[gi][0]),
            .rsp0_valid (rsp_valid0[gi]),
            .rsp0_ready (rsp_ready[gi][0]),
            .rsp0_data  (rsp_data0[gi]),
            .req1_valid (req_valid[gi][1]),
            .req1_ready (req_ready1[gi]),
            .req1_op    (req_op[gi][1]),
            .req1_a     (req_a[gi][1]),
            .req1_b     (req_b[gi][1]),
            .rsp1_valid (rsp_valid1[gi]),
            .rsp1_ready (rsp_ready[gi][1]),
            .rsp1_data  (rsp_data1[gi]),
            .alu_op     (alu_op[gi]),
            .alu_a      (alu_a[gi]),
            .alu_b      (alu_b[gi]),
            .alu_out    (alu_out[gi])
        );
        assign alu_out[gi] = alu_ref(alu_op[gi], alu_a[gi], alu_b[gi]);
    end

    function automatic logic [1:0] ready_pair(int i);
        return {req_ready1[i], req_ready0[i]};
    endfunction

    function automatic logic [1:0] valid_pair(int i);
        return {rsp_valid1[i], rsp_valid0[i]};
    endfunction

    function automatic logic [W-1:0] data_of(int i, int n);
        return (n == 1) ? rsp_data1[i] : rsp_data0[i];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_op(input int i, input int n, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        pend[i][n] = 1'b1;
        q_op[i][n] = op;
        q_a[i][n]  = a;
        q_b[i][n]  = b;
    endtask

    task automatic rand_op(input int i, input int n);
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        op = 2'($urandom_range(0, 3));
        a  = W'($urandom);
        b  = (op == 2'd2) ? W'($urandom_range(0, 12)) : W'($urandom);
        new_op(i, n, op, a, b);
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        check($sformatf("%s_i%0d ready", tag, i), 32'(ready_pair(i)), 32'd0);
        check($sformatf("%s_i%0d rsp_valid", tag, i), 32'(valid_pair(i)), 32'd0);
        check($sformatf("%s_i%0d rsp_data", tag, i), {16'd0, rsp_data1[i], rsp_data0[i]}, 32'd0);
        check($sformatf("%s_i%0d alu", tag, i), {14'd0, alu_op[i], alu_a[i], alu_b[i]}, 32'd0);
`ifdef ALU_ARB_STATS_EN
        check($sformatf("%s_i%0d gcnt", tag, i), {gcnt1[i], gcnt0[i]}, 32'd0);
`endif
    endtask

    // One complete transaction on instance i. Entered just after a falling
    // edge with the IDLE state; returns just after a falling edge.
    task automatic serve_one(input int i, input int hold, input string tag, output int w_out);
        int           w;
        int           o;
        logic [1:0]   e_op;
        logic [W-1:0] e_a;
        logic [W-1:0] e_b;
        logic [W-1:0] e_res;
        for (int n = 0; n < 2; n++) begin
            req_valid[i][n] = pend[i][n];
            req_op[i][n]    = q_op[i][n];
            req_a[i][n]     = q_a[i][n];
            req_b[i][n]     = q_b[i][n];
        end
        // The requester served less recently wins a tie.
        if (pend[i][0] && pend[i][1]) w = (last_served[i] == 0) ? 1 : 0;
        else                          w = pend[i][1] ? 1 : 0;
        o     = 1 - w;
        e_op  = q_op[i][w];
        e_a   = q_a[i][w];
        e_b   = q_b[i][w];
        e_res = alu_ref(e_op, e_a, e_b);
`ifdef ALU_ARB_STATS_EN
        stats_clr[i] = clr_at_accept;
`endif
        #1;
        check($sformatf("%s grant", tag), 32'(ready_pair(i)), (w == 1) ? 32'd2 : 32'd1);
        @(negedge clk);
`ifdef ALU_ARB_STATS_EN
        stats_clr[i] = 1'b0;
`endif
        if (clr_at_accept) begin
            gexp[i][0] = 0;
            gexp[i][1] = 0;
        end else begin
            gexp[i][w]++;
        end
        clr_at_accept = 1'b0;
        // Accepted: drop valid and scramble operands, which must be ignored.
        pend[i][w]      = 1'b0;
        req_valid[i][w] = 1'b0;
        req_op[i][w]    = 2'($urandom);
        req_a[i][w]     = W'($urandom);
        req_b[i][w]     = W'($urandom);
        for (int c = 0; c < lat_of(i); c++) begin
            #1;
            check($sformatf("%s exec%0d rsp_valid", tag, c), 32'(valid_pair(i)), 32'd0);
            check($sformatf("%s exec%0d ready", tag, c), 32'(ready_pair(i)), 32'd0);
            check($sformatf("%s exec%0d alu_in", tag, c),
                  {14'd0, alu_op[i], alu_a[i], alu_b[i]}, {14'd0, e_op, e_a, e_b});
            @(negedge clk);
        end
        #1;
        check($sformatf("%s rsp_valid", tag), 32'(valid_pair(i)), (w == 1) ? 32'd2 : 32'd1);
        check($sformatf("%s rsp_data", tag), 32'(data_of(i, w)), 32'(e_res));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check($sformatf("%s hold%0d rsp_valid", tag, h), 32'(valid_pair(i)), (w == 1) ? 32'd2 : 32'd1);
            check($sformatf("%s hold%0d rsp_data", tag, h), 32'(data_of(i, w)), 32'(e_res));
            check($sformatf("%s hold%0d ready", tag, h), 32'(ready_pair(i)), 32'd0);
        end
        rsp_ready[i][w] = 1'b1;
        rsp_ready[i][o] = 1'($urandom_range(0, 1));
        @(negedge clk);
        rsp_ready[i] = 2'b00;
        #1;
        check($sformatf("%s rsp_drop", tag), 32'(valid_pair(i)), 32'd0);
        last_served[i] = w;
        w_out = w;
    endtask

    initial begin
        int w;
        int issued;

        for (int i = 0; i < 2; i++) begin
            rst_n[i]       = 1'b0;
            req_valid[i]   = '0;
            req_op[i]      = '0;
            req_a[i]       = '0;
            req_b[i]       = '0;
            rsp_ready[i]   = '0;
            last_served[i] = 1;
`ifdef ALU_ARB_STATS_EN
            stats_clr[i]   = 1'b0;
`endif
            for (int n = 0; n < 2; n++) begin
                pend[i][n] = 1'b0;
                gexp[i][n] = 0;
            end
        end
        clr_at_accept = 1'b0;

        // Test 1: request already pending while reset is held.
        new_op(0, 0, 2'b11, 8'hF0, 8'h20);
        req_valid[0][0] = 1'b1;
        req_op[0][0]    = 2'b11;
        req_a[0][0]     = 8'hF0;
        req_b[0][0]     = 8'h20;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs(0, "t1_reset");
        check_reset_outputs(1, "t1_reset");
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Test 2: add with wrap, F0+20 -> 10, one-cycle latency.
        serve_one(0, 0, "t2_add", w);

        // Test 3: simultaneous requests straight after reset.
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        last_served[0] = 1;
        gexp[0][0] = 0;
        gexp[0][1] = 0;
        new_op(0, 0, 2'b00, 8'hCC, 8'hAA);
        new_op(0, 1, 2'b01, 8'hCC, 8'hAA);
        serve_one(0, 0, "t3_first", w);
        serve_one(0, 0, "t3_second", w);

        // Test 4: continuous contention over six operations, with shifts.
`ifdef ALU_ARB_STATS_EN
        stats_clr[0] = 1'b1;
        @(negedge clk);
        stats_clr[0] = 1'b0;
        #1;
        check("t4_clear gcnt", {gcnt1[0], gcnt0[0]}, 32'd0);
`endif
        gexp[0][0] = 0;
        gexp[0][1] = 0;
        issued = 0;
        for (int k = 0; k < 6; k++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[0][n] && issued < 6) begin
                    if (issued == 0)      new_op(0, n, 2'b10, 8'h81, 8'd3);
                    else if (issued == 1) new_op(0, n, 2'b10, 8'h81, 8'd9);
                    else                  rand_op(0, n);
                    issued++;
                end
            end
            serve_one(0, 0, $sformatf("t4_op%0d", k), w);
        end
`ifdef ALU_ARB_STATS_EN
        check("t4 gcnt0", 32'(gcnt0[0]), 32'd3);
        check("t4 gcnt1", 32'(gcnt1[0]), 32'd3);
`endif

        // Test 5: owner stalls the response for five cycles, other waits.
        rand_op(0, 0);
        rand_op(0, 1);
        serve_one(0, 5, "t5_held", w);
        serve_one(0, 0, "t5_next", w);

`ifdef ALU_ARB_STATS_EN
        // Clear coinciding with an accept: the clear wins.
        rand_op(0, 0);
        clr_at_accept = 1'b1;
        serve_one(0, 0, "clr_vs_acc", w);
        check("clr_vs_acc gcnt", {gcnt1[0], gcnt0[0]}, 32'd0);
`endif

        // Test 6: ALU_LAT=4 instance, reset while an operation is in EXEC.
        rand_op(1, 0);
        serve_one(1, 0, "t6_warm", w);
        rand_op(1, 0);
        req_valid[1][0] = 1'b1;
        req_op[1][0]    = q_op[1][0];
        req_a[1][0]     = q_a[1][0];
        req_b[1][0]     = q_b[1][0];
        #1;
        check("t6_accept ready", 32'(ready_pair(1)), 32'd1);
        @(negedge clk);
        req_valid[1][0] = 1'b0;
        pend[1][0] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        check_reset_outputs(1, "t6_in_reset");
        @(negedge clk);
        rst_n[1] = 1'b1;
        last_served[1] = 1;
        gexp[1][0] = 0;
        gexp[1][1] = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("t6_no_rsp%0d", c), 32'(valid_pair(1)), 32'd0);
            @(negedge clk);
        end
        rand_op(1, 0);
        rand_op(1, 1);
        serve_one(1, 0, "t6_after_a", w);
        serve_one(1, 0, "t6_after_b", w);

        // Randomized traffic on both instances, drained before moving on.
        for (int i = 0; i < 2; i++) begin
            for (int it = 0; it < ((i == 0) ? 40 : 15); it++) begin
                for (int n = 0; n < 2; n++) begin
                    if (!pend[i][n] && ($urandom_range(0, 1) == 1)) rand_op(i, n);
                end
                if (!pend[i][0] && !pend[i][1]) rand_op(i, int'($urandom_range(0, 1)));
                serve_one(i, int'($urandom_range(0, 3)), $sformatf("rnd_i%0d_%0d", i, it), w);
            end
            while (pend[i][0] || pend[i][1]) begin
                serve_one(i, 0, $sformatf("drain_i%0d", i), w);
            end
        end

`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < 2; i++) begin
            check($sformatf("end_i%0d gcnt0", i), 32'(gcnt0[i]), 32'(gexp[i][0]));
            check($sformatf("end_i%0d gcnt1", i), 32'(gcnt1[i]), 32'(gexp[i][1]));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
